// File: rtl/timer0_pkg.sv
// Shared encodings and helpers for the Timer/Counter0 slice.
// The PWM modes exist only when TIMER0_PWM_EN is defined.
package timer0_pkg;

    typedef enum logic [1:0] {
        WGM_NORMAL = 2'b00,
        WGM_PCPWM  = 2'b01,
        WGM_CTC    = 2'b10,
        WGM_FPWM   = 2'b11
    } wgm_e;

    typedef enum logic [1:0] {
        COM_OFF    = 2'b00,
        COM_TOGGLE = 2'b01,
        COM_CLEAR  = 2'b10,
        COM_SET    = 2'b11
    } com_e;

    localparam int unsigned BOTTOM = 0;

    function automatic int unsigned top_of(input int unsigned width);
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage

// File: rtl/timer0_counter_if.sv
// Register/strobe bundle between the Timer0 register file and the counter core.
// Config macro: TIMER0_PWM_EN (no effect on the interface itself).
interface timer0_counter_if #(
    parameter int unsigned WIDTH = 8
);
    logic             tick;
    logic [1:0]       wgm;
    logic [1:0]       com;
    logic             foc;
    logic             tcnt_we;
    logic [WIDTH-1:0] tcnt_wdata;
    logic             ocr_we;
    logic [WIDTH-1:0] ocr_wdata;
    logic             tov_clr;
    logic             ocf_clr;
    logic [WIDTH-1:0] tcnt;
    logic [WIDTH-1:0] ocr;
    logic             tov;
    logic             ocf;
    logic             oc0;

    modport master (
        output tick, wgm, com, foc, tcnt_we, tcnt_wdata, ocr_we, ocr_wdata,
               tov_clr, ocf_clr,
        input  tcnt, ocr, tov, ocf, oc0
    );

    modport slave (
        input  tick, wgm, com, foc, tcnt_we, tcnt_wdata, ocr_we, ocr_wdata,
               tov_clr, ocf_clr,
        output tcnt, ocr, tov, ocf, oc0
    );
endinterface

// File: rtl/timer0_waveform.sv
// OC0 waveform generator: applies the COM0 action on compare/wrap events.
// Config macro: TIMER0_PWM_EN enables the fast and phase-correct PWM behaviours.
module timer0_waveform
    import timer0_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  wgm_e       mode,
    input  logic [1:0] com,
    input  logic       match,
    input  logic       dir_up,
    input  logic       top_wrap,
    input  logic       foc,
    output logic       oc0
);

`ifndef TIMER0_PWM_EN
    logic unused_pwm;
    assign unused_pwm = dir_up ^ top_wrap;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oc0 <= 1'b0;
        end else begin
            case (mode)
`ifdef TIMER0_PWM_EN
                // Wrap wins over a same-tick match so OCR=TOP gives a steady level.
                WGM_FPWM: begin
                    if (com[1]) begin
                        if (top_wrap)
                            oc0 <= (com == COM_CLEAR);
                        else if (match)
                            oc0 <= (com == COM_SET);
                    end
                end
                WGM_PCPWM: begin
                    if (com[1] && match)
                        oc0 <= dir_up ^ (com == COM_CLEAR);
                end
`endif
                default: begin
                    if (match || foc) begin
                        case (com)
                            COM_TOGGLE: oc0 <= ~oc0;
                            COM_CLEAR:  oc0 <= 1'b0;
                            COM_SET:    oc0 <= 1'b1;
                            default:    ;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/timer0_counter.sv
// Timer/Counter0 core: TCNT0, OCR0 (double-buffered in PWM), TOV0/OCF0 and OC0.
// Config macro: TIMER0_PWM_EN adds fast/phase-correct PWM and the OCR buffer.
module timer0_counter
    import timer0_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input logic            clk,
    input logic            rst_n,
    timer0_counter_if.slave bus
);

    localparam logic [WIDTH-1:0] TOP_V = WIDTH'(top_of(WIDTH));
    localparam logic [WIDTH-1:0] BOT_V = WIDTH'(BOTTOM);

    function automatic wgm_e eff_mode(input logic [1:0] w);
`ifdef TIMER0_PWM_EN
        return wgm_e'(w);
`else
        return w[1] ? WGM_CTC : WGM_NORMAL;
`endif
    endfunction

    wgm_e             mode;
    logic [WIDTH-1:0] tcnt_q;
    logic [WIDTH-1:0] ocr_q;
    logic [WIDTH-1:0] tcnt_nxt;
    logic             tov_q;
    logic             ocf_q;
    logic             block;
    logic             dir_up;
    logic             run;
    logic             at_top;
    logic             match;
    logic             tov_set;
    logic             top_wrap;
    logic             pwm_mode;
    logic             foc_ok;
    logic             oc0_w;
`ifdef TIMER0_PWM_EN
    logic [WIDTH-1:0] ocr_buf;
    logic             at_bot;
    logic             dir_up_nxt;
    logic             load_buf;
`endif

    always_comb begin
        mode     = eff_mode(bus.wgm);
        pwm_mode = (mode == WGM_PCPWM) || (mode == WGM_FPWM);
        // A TCNT write swallows a same-cycle tick entirely.
        run      = bus.tick && !bus.tcnt_we;
        at_top   = (tcnt_q == TOP_V);
        match    = run && (tcnt_q == ocr_q) && !block;
        tcnt_nxt = tcnt_q + 1'b1;
        tov_set  = run && at_top;
        top_wrap = 1'b0;
        foc_ok   = bus.foc && !pwm_mode;
`ifdef TIMER0_PWM_EN
        at_bot     = (tcnt_q == BOT_V);
        dir_up_nxt = 1'b1;
        load_buf   = 1'b0;
`endif
        case (mode)
            WGM_CTC: begin
                if (match)
                    tcnt_nxt = BOT_V;
            end
`ifdef TIMER0_PWM_EN
            WGM_FPWM: begin
                top_wrap = run && at_top;
                load_buf = run && at_top;
            end
            WGM_PCPWM: begin
                dir_up_nxt = dir_up ? !at_top : at_bot;
                tcnt_nxt   = dir_up_nxt ? tcnt_q + 1'b1 : tcnt_q - 1'b1;
                tov_set    = run && !dir_up && at_bot;
                load_buf   = run && at_top;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt_q <= '0;
            ocr_q  <= '0;
            tov_q  <= 1'b0;
            ocf_q  <= 1'b0;
            block  <= 1'b0;
        end else begin
            if (bus.tcnt_we) begin
                tcnt_q <= bus.tcnt_wdata;
                block  <= 1'b1;
            end else if (bus.tick) begin
                tcnt_q <= tcnt_nxt;
                block  <= 1'b0;
            end
`ifdef TIMER0_PWM_EN
            if (bus.ocr_we && !pwm_mode)
                ocr_q <= bus.ocr_wdata;
            else if (load_buf)
                ocr_q <= ocr_buf;
`else
            if (bus.ocr_we)
                ocr_q <= bus.ocr_wdata;
`endif
            tov_q <= tov_set || (tov_q && !bus.tov_clr);
            ocf_q <= match || (ocf_q && !bus.ocf_clr);
        end
    end

`ifdef TIMER0_PWM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ocr_buf <= '0;
            dir_up  <= 1'b1;
        end else begin
            if (bus.ocr_we)
                ocr_buf <= bus.ocr_wdata;
            if (mode != WGM_PCPWM)
                dir_up <= 1'b1;
            else if (run)
                dir_up <= dir_up_nxt;
        end
    end
`else
    assign dir_up = 1'b1;
`endif

    timer0_waveform u_wave (
        .clk      (clk),
        .rst_n    (rst_n),
        .mode     (mode),
        .com      (bus.com),
        .match    (match),
        .dir_up   (dir_up),
        .top_wrap (top_wrap),
        .foc      (foc_ok),
        .oc0      (oc0_w)
    );

    assign bus.tcnt = tcnt_q;
    assign bus.ocr  = ocr_q;
    assign bus.tov  = tov_q;
    assign bus.ocf  = ocf_q;
    assign bus.oc0  = oc0_w;

endmodule

// File: tb/tb_timer0_counter.sv
// Directed bench for timer0_counter with a rule-level reference model checked every cycle.
// Follows TIMER0_PWM_EN the same way as the design build.
module tb_timer0_counter;

`ifdef TIMER0_PWM_EN
    localparam bit PWM_EN = 1'b1;
`else
    localparam bit PWM_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    bit   chk_on = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;

    timer0_counter_if #(.WIDTH(8)) bus ();

    timer0_counter #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp)
            n_pass++;
        else
            $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
    endtask

    // Reference model: counter position, direction as +1/-1, flags and pin level.
    int m_tcnt, m_ocr, m_buf, m_dir;
    bit m_tov, m_ocf, m_oc0, m_blk;

    task automatic model_reset();
        m_tcnt = 0; m_ocr = 0; m_buf = 0; m_dir = 1;
        m_tov = 0; m_ocf = 0; m_oc0 = 0; m_blk = 0;
    endtask

    task automatic model_step();
        int md, nt, nd, nocr, cm;
        bit pwm, run, mt, tovs, wrap;
        md = int'(bus.wgm);
        cm = int'(bus.com);
        if (!PWM_EN) md = (md >= 2) ? 2 : 0;
        pwm  = (md == 1) || (md == 3);
        run  = bus.tick && !bus.tcnt_we;
        mt   = run && (m_tcnt == m_ocr) && !m_blk;
        nt   = m_tcnt;
        nd   = (md == 1) ? m_dir : 1;
        tovs = 0;
        wrap = 0;
        if (run) begin
            case (md)
                1: begin
                    if (m_tcnt == 255 && m_dir > 0) nd = -1;
                    else if (m_tcnt == 0 && m_dir < 0) nd = 1;
                    nt   = m_tcnt + nd;
                    tovs = (m_tcnt == 0) && (m_dir < 0);
                end
                2: begin
                    nt   = mt ? 0 : (m_tcnt + 1) % 256;
                    tovs = (m_tcnt == 255);
                end
                default: begin
                    nt   = (m_tcnt + 1) % 256;
                    tovs = (m_tcnt == 255);
                    wrap = (md == 3) && tovs;
                end
            endcase
        end
        case (md)
            3: if (cm >= 2) begin
                if (wrap) m_oc0 = (cm == 2);
                else if (mt) m_oc0 = (cm == 3);
            end
            1: if (cm >= 2 && mt) m_oc0 = (cm == 2) ? (m_dir < 0) : (m_dir > 0);
            default: if (mt || bus.foc) begin
                if (cm == 1) m_oc0 = !m_oc0;
                else if (cm == 2) m_oc0 = 0;
                else if (cm == 3) m_oc0 = 1;
            end
        endcase
        nocr = m_ocr;
        if (pwm && run && m_tcnt == 255) nocr = m_buf;
        if (bus.ocr_we) begin
            m_buf = int'(bus.ocr_wdata);
            if (!pwm) nocr = int'(bus.ocr_wdata);
        end
        m_ocr = nocr;
        m_tov = tovs || (m_tov && !bus.tov_clr);
        m_ocf = mt || (m_ocf && !bus.ocf_clr);
        if (bus.tcnt_we) begin
            m_tcnt = int'(bus.tcnt_wdata);
            m_blk  = 1;
        end else if (bus.tick) begin
            m_tcnt = nt;
            m_blk  = 0;
        end
        m_dir = nd;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else model_step();
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("cmp_tcnt", int'(bus.tcnt), m_tcnt);
            chk("cmp_ocr",  int'(bus.ocr),  m_ocr);
            chk("cmp_tov",  int'(bus.tov),  int'(m_tov));
            chk("cmp_ocf",  int'(bus.ocf),  int'(m_ocf));
            chk("cmp_oc0",  int'(bus.oc0),  int'(m_oc0));
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic strobes_off();
        bus.foc = 0; bus.tcnt_we = 0; bus.ocr_we = 0;
        bus.tov_clr = 0; bus.ocf_clr = 0;
    endtask

    initial begin
        bus.tick = 0; bus.wgm = 0; bus.com = 0;
        bus.tcnt_wdata = 0; bus.ocr_wdata = 0;
        strobes_off();
        cyc(3);
        chk_on = 1;
        rst_n  = 1;
        chk("rst_tcnt", int'(bus.tcnt), 0);
        chk("rst_ocr",  int'(bus.ocr),  0);
        chk("rst_tov",  int'(bus.tov),  0);
        chk("rst_ocf",  int'(bus.ocf),  0);
        chk("rst_oc0",  int'(bus.oc0),  0);

        // Normal mode, free running from reset
        bus.tick = 1;
        cyc(255);
        chk("nrm_top", int'(bus.tcnt), 255);
        chk("nrm_tov_pre", int'(bus.tov), 0);
        cyc(1);
        chk("nrm_wrap", int'(bus.tcnt), 0);
        chk("nrm_tov", int'(bus.tov), 1);
        bus.tick = 0; bus.tov_clr = 1; bus.ocf_clr = 1;
        cyc(1);
        strobes_off();
        chk("nrm_tov_clr", int'(bus.tov), 0);

        // CTC, ocr=9, toggle
        bus.wgm = 2; bus.com = 1;
        bus.ocr_we = 1; bus.ocr_wdata = 9; bus.tcnt_we = 1; bus.tcnt_wdata = 0;
        cyc(1);
        strobes_off();
        chk("ctc_ocr", int'(bus.ocr), 9);
        bus.tick = 1;
        cyc(10);
        chk("ctc_clear", int'(bus.tcnt), 0);
        chk("ctc_ocf", int'(bus.ocf), 1);
        chk("ctc_oc0_a", int'(bus.oc0), 1);
        bus.ocf_clr = 1;
        cyc(1);
        strobes_off();
        chk("ctc_ocf_clr", int'(bus.ocf), 0);
        cyc(9);
        chk("ctc_clear2", int'(bus.tcnt), 0);
        chk("ctc_ocf2", int'(bus.ocf), 1);
        chk("ctc_oc0_b", int'(bus.oc0), 0);
        chk("ctc_tov", int'(bus.tov), 0);
        bus.tick = 0;

        // Fast PWM, ocr=64, non-inverting
        bus.wgm = 0; bus.com = 2;
        bus.ocr_we = 1; bus.ocr_wdata = 64; bus.tcnt_we = 1; bus.tcnt_wdata = 0;
        bus.ocf_clr = 1; bus.tov_clr = 1;
        cyc(1);
        strobes_off();
        bus.wgm = 3; bus.tick = 1;
`ifdef TIMER0_PWM_EN
        cyc(256);
        chk("fp_wrap", int'(bus.tcnt), 0);
        chk("fp_set", int'(bus.oc0), 1);
        cyc(64);
        chk("fp_hi64", int'(bus.oc0), 1);
        cyc(1);
        chk("fp_cnt65", int'(bus.tcnt), 65);
        chk("fp_lo65", int'(bus.oc0), 0);
        bus.ocr_we = 1; bus.ocr_wdata = 128;
        cyc(1);
        strobes_off();
        chk("fp_buf_hold", int'(bus.ocr), 64);
        cyc(189);
        chk("fp_top", int'(bus.tcnt), 255);
        chk("fp_buf_hold2", int'(bus.ocr), 64);
        cyc(1);
        chk("fp_buf_load", int'(bus.ocr), 128);
        cyc(128);
        chk("fp_hi128", int'(bus.oc0), 1);
        cyc(1);
        chk("fp_lo129", int'(bus.oc0), 0);
`else
        cyc(65);
        chk("fp_as_ctc", int'(bus.tcnt), 0);
        chk("fp_as_ctc_ocf", int'(bus.ocf), 1);
        bus.ocr_we = 1; bus.ocr_wdata = 128;
        cyc(1);
        strobes_off();
        chk("fp_direct_ocr", int'(bus.ocr), 128);
`endif
        bus.tick = 0;

        // Phase-correct PWM, ocr=100; foc presets oc0 high first
        bus.wgm = 0; bus.com = 3; bus.foc = 1;
        bus.ocr_we = 1; bus.ocr_wdata = 100; bus.tcnt_we = 1; bus.tcnt_wdata = 0;
        bus.ocf_clr = 1; bus.tov_clr = 1;
        cyc(1);
        strobes_off();
        chk("foc_set", int'(bus.oc0), 1);
        chk("foc_no_ocf", int'(bus.ocf), 0);
        bus.wgm = 1; bus.com = 2; bus.tick = 1;
        cyc(100);
        chk("pc_cnt100", int'(bus.tcnt), 100);
        chk("pc_hi", int'(bus.oc0), 1);
        cyc(1);
        chk("pc_upmatch", int'(bus.oc0), 0);
`ifdef TIMER0_PWM_EN
        cyc(154);
        chk("pc_top", int'(bus.tcnt), 255);
        chk("pc_tov_top", int'(bus.tov), 0);
        cyc(1);
        chk("pc_down", int'(bus.tcnt), 254);
        cyc(154);
        chk("pc_cnt100d", int'(bus.tcnt), 100);
        chk("pc_lo", int'(bus.oc0), 0);
        cyc(1);
        chk("pc_dnmatch", int'(bus.oc0), 1);
        cyc(99);
        chk("pc_bottom", int'(bus.tcnt), 0);
        chk("pc_tov_pre", int'(bus.tov), 0);
        cyc(1);
        chk("pc_up_again", int'(bus.tcnt), 1);
        chk("pc_tov", int'(bus.tov), 1);
`else
        cyc(155);
        chk("pc_as_nrm", int'(bus.tcnt), 0);
        chk("pc_as_nrm_tov", int'(bus.tov), 1);
`endif
        bus.tick = 0;

        // TCNT write blocks the compare for one tick
        bus.wgm = 0; bus.com = 0;
        bus.ocr_we = 1; bus.ocr_wdata = 50; bus.ocf_clr = 1; bus.tov_clr = 1;
        cyc(1);
        strobes_off();
        bus.tcnt_we = 1; bus.tcnt_wdata = 50; bus.tick = 1;
        cyc(1);
        strobes_off();
        chk("we_beats_tick", int'(bus.tcnt), 50);
        cyc(1);
        chk("blk_cnt", int'(bus.tcnt), 51);
        chk("blk_no_ocf", int'(bus.ocf), 0);
        cyc(255);
        chk("pass2_cnt", int'(bus.tcnt), 50);
        chk("pass2_pre", int'(bus.ocf), 0);
        cyc(1);
        chk("pass2_ocf", int'(bus.ocf), 1);
        cyc(149);
        chk("pre_rst_cnt", int'(bus.tcnt), 200);

        // Asynchronous reset in mid-cycle
        #2 rst_n = 0;
        #1;
        chk("arst_tcnt", int'(bus.tcnt), 0);
        chk("arst_ocr",  int'(bus.ocr),  0);
        chk("arst_tov",  int'(bus.tov),  0);
        chk("arst_ocf",  int'(bus.ocf),  0);
        chk("arst_oc0",  int'(bus.oc0),  0);
        bus.tick = 0;
        cyc(2);
        rst_n = 1;
        cyc(3);
        chk("post_tcnt", int'(bus.tcnt), 0);
        chk("post_ocf",  int'(bus.ocf),  0);
        chk("post_oc0",  int'(bus.oc0),  0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/timer0_counter.md
# timer0_counter

8-bit Timer/Counter0 core for the ATMega32A emulator. It sits directly downstream of the Timer0 prescaler/clock-select stage and advances TCNT0 on each prescaled tick. It implements the four WGM0 modes, OCR0 compare with double buffering in PWM modes, the TOV0/OCF0 flags and the OC0 waveform output. Everything is synchronous to the system clock; the prescaled clock arrives as a one-cycle enable, not as a derived clock.

## Interface
- WIDTH, 8, counter/compare width; TOP = 2^WIDTH-1
- clk  in  1  system clock; all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- tick  in  1  prescaled count enable, one clk wide; low = clock stopped (CS0=000)
- wgm  in  2  mode: 00 normal, 01 phase-correct PWM, 10 CTC, 11 fast PWM
- com  in  2  compare output mode
- foc  in  1  force output compare strobe
- tcnt_we / tcnt_wdata  in  1 / WIDTH  TCNT0 write
- ocr_we / ocr_wdata  in  1 / WIDTH  OCR0 buffer write
- tov_clr / ocf_clr  in  1  write-one-to-clear strobes
- tcnt  out  WIDTH  current count
- ocr  out  WIDTH  active compare value
- tov / ocf  out  1  overflow / compare-match flags
- oc0  out  1  waveform output

## Operation
- Reset values: tcnt=0, ocr=0, OCR buffer=0, tov=0, ocf=0, oc0=0, direction=up, compare block=0.
- Match: tick && tcnt==ocr && !block. Block is set by tcnt_we and clears on the next tick.
- Normal: count 0..TOP, wrapping to 0. tov sets on the tick where tcnt==TOP.
- CTC: on a match, next tcnt=0; otherwise increment. tov sets only on TOP→0 (e.g. ocr=TOP).
- Fast PWM: count 0..TOP and wrap. tov sets at TOP. Buffer copies to ocr on the tick at TOP.
- Phase-correct: count up to TOP, then down to 0.
  - Direction flips on the tick at TOP and at 0.
  - tov sets on the tick at 0 while counting down.
  - Buffer copies to ocr on the tick at TOP.
- OCR writes:
  - Non-PWM modes: ocr_we writes ocr directly.
  - PWM modes: ocr_we writes the buffer only.
- ocf sets on every match.
- oc0, non-PWM modes (com):
  - 00: hold
  - 01: toggle on match
  - 10: clear on match
  - 11: set on match
- oc0, fast PWM (com):
  - 10: clear on match, set at TOP→0
  - 11: set on match, clear at TOP→0
  - 00/01: hold
- oc0, phase-correct (com):
  - 10: clear on up-count match, set on down-count match
  - 11: the inverse
  - 00/01: hold
- foc: accepted only in non-PWM modes. Applies the com action to oc0 immediately. Does not set ocf and does not reset tcnt in CTC. Ignored in PWM modes.
- Priorities:
  - tcnt_we beats tick: the written value is loaded, no increment.
  - A flag set beats a same-cycle clear.
  - ocr_we in a non-PWM mode beats the buffer copy.
- Mode change: takes effect on the next tick. Leaving phase-correct forces direction=up.
- rst_n asserted mid-count: all state returns to reset values immediately. Counting resumes on the first tick after release.

## Timing
- tcnt, tov, ocf and oc0 update on the clk edge that samples tick=1. Latency from tick to outputs is one clk.
- A TCNT/OCR write is visible on the outputs the next clk.
- No change occurs while tick=0, except writes, flag clears, foc and reset.
- Flags are sticky until a clear strobe or reset.

## Configuration
- TIMER0_PWM_EN defined: all four modes as above.
- TIMER0_PWM_EN undefined: PWM logic and the OCR buffer are removed.
  - wgm 01 behaves as normal; wgm 11 behaves as CTC.
  - ocr_we always writes ocr directly; foc is accepted in every mode.

## Structure
- Package timer0_pkg holds:
  - WGM encodings (WGM_NORMAL, WGM_PCPWM, WGM_CTC, WGM_FPWM)
  - COM encodings
  - BOTTOM=0
  - TOP function of WIDTH
- Sub-module timer0_waveform generates oc0 from mode, com, match, direction, top/bottom events and foc.
- timer0_counter holds tcnt, direction, buffer and flags.

## Test plan
- Normal, tick every clk, from reset → tcnt 0..255, then 0; tov=1 on the clk after tcnt=255; tov_clr drops it.
- CTC, ocr=9, com=01 → tcnt cycles 0..9; ocf sets every 10 ticks; oc0 toggles every 10 ticks; tov stays 0.
- Fast PWM, ocr=64, com=10 → oc0 high for ticks 0..64, low for 65..255. An ocr_we of 128 mid-period takes effect only after TOP.
- Phase-correct, ocr=100, com=10 → count 0↑255↓0 over 510 ticks; oc0 low from up-match to down-match; tov at bottom only.
- tcnt_we=50 with ocr=50 in normal → no match on the next tick; a match occurs on the next pass. tcnt_we and tick in the same cycle → tcnt=50.
- Mid-count rst_n pulse at tcnt=200, ocf=1 → all outputs 0 immediately. With tick=0 after release, everything stays 0.
